// File: rtl/boot_rom_arb_pkg.sv
// Shared types and constants for the boot ROM arbiter: response tracking record,
// default addresses/error word and the master-index width helper.
package boot_rom_arb_pkg;

  // Upper bound on requesters; the owner field of resp_t is sized for it.
  localparam int MAX_NB_MASTERS = 8;

  localparam logic [31:0] BOOT_ROM_BASE_DEFAULT = 32'h1A00_0000;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADA_CCE5;

  typedef struct packed {
    logic                      valid;
    logic [MAX_NB_MASTERS-1:0] owner;
    logic                      err;
  } resp_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/boot_rom_arbiter_if.sv
// TCDM-style requester bundle between the SoC interconnect and the boot ROM arbiter.
interface boot_rom_arbiter_if #(
  parameter int NB_MASTERS = 3
);
  logic [NB_MASTERS-1:0]        m_req;
  logic [NB_MASTERS-1:0][31:0]  m_add;
  logic [NB_MASTERS-1:0]        m_wen;
  logic [NB_MASTERS-1:0]        m_gnt;
  logic [NB_MASTERS-1:0]        m_r_valid;
  logic [NB_MASTERS-1:0][31:0]  m_r_rdata;
  logic [NB_MASTERS-1:0]        m_r_opc;

  modport master (
    output m_req, m_add, m_wen,
    input  m_gnt, m_r_valid, m_r_rdata, m_r_opc
  );

  modport slave (
    input  m_req, m_add, m_wen,
    output m_gnt, m_r_valid, m_r_rdata, m_r_opc
  );
endinterface

// File: rtl/boot_rom_rr_arb.sv
// Round-robin grant generator: one-hot grant plus index, search starts at the
// pointer, pointer moves past the winner and holds when nobody requests.
module boot_rom_rr_arb
  import boot_rom_arb_pkg::*;
#(
  parameter int NB_MASTERS = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_MASTERS-1:0]               req,
  output logic [NB_MASTERS-1:0]               gnt,
  output logic [idx_width(NB_MASTERS)-1:0]    gnt_idx
);

  localparam int IW = idx_width(NB_MASTERS);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic          found;
  logic [IW-1:0] cand_idx;
  int            cand;

  always_comb begin
    gnt      = '0;
    gnt_idx  = ptr_reg;
    ptr_next = ptr_reg;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int o = 0; o < NB_MASTERS; o++) begin
      cand = int'(ptr_reg) + o;
      if (cand >= NB_MASTERS) cand = cand - NB_MASTERS;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
    if (found) begin
      ptr_next = (gnt_idx == IW'(NB_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Boot ROM arbiter: round-robin sharing of the single-port ROM, access checking and
// response routing. Define BOOT_ROM_ARB_RESP_REG_EN for an extra response register stage.
module boot_rom_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter int          NB_MASTERS     = 3,
  parameter int          ROM_ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR      = BOOT_ROM_BASE_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  boot_rom_arbiter_if.slave           bus,
  output logic                        rom_cen_o,
  output logic [ROM_ADDR_WIDTH-3:0]   rom_addr_o,
  input  logic [31:0]                 rom_q_i
);

  localparam int IW = idx_width(NB_MASTERS);
  localparam int WW = ROM_ADDR_WIDTH - 2;

  logic [NB_MASTERS-1:0] req_eff;
  logic [NB_MASTERS-1:0] gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic [31:0]           add_sel;
  logic [29:0]           off_word;
  logic                  legal;

  // No grants may escape while reset is held, even though the request lines are live.
  assign req_eff = rst_i ? '0 : bus.m_req;

  boot_rom_rr_arb #(
    .NB_MASTERS(NB_MASTERS)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_eff),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.m_gnt = gnt;
  assign gnt_any   = |gnt;

  // Offset wraps modulo 2**32, so addresses below the base land far out of range.
  assign add_sel  = bus.m_add[gnt_idx];
  assign off_word = 30'((add_sel - BASE_ADDR) >> 2);
  assign legal    = !bus.m_wen[gnt_idx] && (off_word[29:WW] == '0);

  assign rom_cen_o  = !(gnt_any && legal);
  assign rom_addr_o = off_word[WW-1:0];

  resp_t resp_reg;
  resp_t resp_next;

  always_comb begin
    resp_next                        = '0;
    resp_next.valid                  = gnt_any;
    resp_next.owner[NB_MASTERS-1:0]  = gnt;
    resp_next.err                    = gnt_any && !legal;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_reg <= '0;
    end else begin
      resp_reg <= resp_next;
    end
  end

  logic                        resp_live;
  logic [NB_MASTERS-1:0]       hit;
  logic [31:0]                 live_rdata;
  logic [NB_MASTERS-1:0][31:0] rdata_reg;
  logic [NB_MASTERS-1:0]       opc_reg;

  assign resp_live  = resp_reg.valid && (|resp_reg.owner);
  assign live_rdata = resp_reg.err ? ERR_RDATA : rom_q_i;

  // Per-master copy of the last response; serves as the hold value or the output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_reg <= '0;
      opc_reg   <= '0;
    end else begin
      for (int i = 0; i < NB_MASTERS; i++) begin
        if (hit[i]) begin
          rdata_reg[i] <= live_rdata;
          opc_reg[i]   <= resp_reg.err;
        end
      end
    end
  end

`ifdef BOOT_ROM_ARB_RESP_REG_EN
  logic [NB_MASTERS-1:0] valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= hit;
    end
  end
`endif

  for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_resp
    assign hit[gi] = resp_live && resp_reg.owner[gi];
`ifdef BOOT_ROM_ARB_RESP_REG_EN
    assign bus.m_r_valid[gi] = valid_reg[gi];
    assign bus.m_r_rdata[gi] = rdata_reg[gi];
    assign bus.m_r_opc[gi]   = opc_reg[gi];
`else
    assign bus.m_r_valid[gi] = hit[gi];
    assign bus.m_r_rdata[gi] = hit[gi] ? live_rdata : rdata_reg[gi];
    assign bus.m_r_opc[gi]   = hit[gi] ? resp_reg.err : opc_reg[gi];
`endif
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Table-driven bench for boot_rom_arbiter: grant/ROM-side vectors checked per cycle,
// responses checked against a scoreboard queue in both latency builds.
module tb_boot_rom_arbiter;

  localparam logic [31:0] BASE = 32'h1A00_0000;
  localparam logic [31:0] ERR  = 32'hBADA_CCE5;
`ifdef BOOT_ROM_ARB_RESP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wen;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  gnt;
    logic        cen;
    logic [10:0] raddr;
  } vec_t;

  typedef struct {
    int          due;
    int          m;
    logic [31:0] rdata;
    logic        opc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rom_cen;
  logic [10:0] rom_addr;
  logic [31:0] rom_q;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  boot_rom_arbiter_if #(.NB_MASTERS(3)) bus();

  boot_rom_arbiter #(
    .NB_MASTERS     (3),
    .ROM_ADDR_WIDTH (13),
    .BASE_ADDR      (BASE),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .rom_cen_o  (rom_cen),
    .rom_addr_o (rom_addr),
    .rom_q_i    (rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return 32'hA500_0000 ^ {a, 21'h0} ^ {21'h0, a};
  endfunction

  initial rom_q = '0;
  always @(posedge clk) if (!rom_cen) rom_q <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic add_vec(input logic [2:0] req, input logic [2:0] wen, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [2:0] gnt,
                         input logic cen, input logic [10:0] raddr);
    vec_t v;
    v.req = req; v.wen = wen; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.gnt = gnt; v.cen = cen; v.raddr = raddr;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.m_req    = v.req;
    bus.m_wen    = v.wen;
    bus.m_add[0] = v.a0;
    bus.m_add[1] = v.a1;
    bus.m_add[2] = v.a2;
  endtask

  // Response monitor: exactly the scheduled master pulses; rdata/opc otherwise hold.
  logic [31:0] last_rd [3];
  logic        last_opc [3];
  logic [2:0]  mon_ev;
  exp_t        mon_e;

  always @(negedge clk) begin
    mon_ev = '0;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        last_rd[i]  = '0;
        last_opc[i] = 1'b0;
      end
      chk("rst_r_valid", 32'(bus.m_r_valid), 32'd0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("resp_due_cycle", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        mon_ev[mon_e.m] = 1'b1;
        last_rd[mon_e.m]  = mon_e.rdata;
        last_opc[mon_e.m] = mon_e.opc;
      end
      chk("r_valid", 32'(bus.m_r_valid), 32'(mon_ev));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r_rdata%0d", i), bus.m_r_rdata[i], last_rd[i]);
      chk($sformatf("r_opc%0d", i), 32'(bus.m_r_opc[i]), 32'(last_opc[i]));
    end
  end

  initial begin
    exp_t e;
    int   m;

    // Round-robin from reset, then single reads (low address bits ignored).
    for (int r = 0; r < 2; r++) begin
      add_vec(3'b111, 3'b000, BASE + 32'h100, BASE + 32'h204, BASE + 32'h1FFC, 3'b001, 1'b0, 11'h040);
      add_vec(3'b111, 3'b000, BASE + 32'h100, BASE + 32'h204, BASE + 32'h1FFC, 3'b010, 1'b0, 11'h081);
      add_vec(3'b111, 3'b000, BASE + 32'h100, BASE + 32'h204, BASE + 32'h1FFC, 3'b100, 1'b0, 11'h7FF);
    end
    add_vec(3'b001, 3'b000, BASE + 32'h10, 32'h0, 32'h0, 3'b001, 1'b0, 11'h004);
    add_vec(3'b001, 3'b000, BASE + 32'h13, 32'h0, 32'h0, 3'b001, 1'b0, 11'h004);
    // Error cases: write, one past the end, below base (offset wraps).
    add_vec(3'b010, 3'b010, 32'h0, BASE, 32'h0, 3'b010, 1'b1, 11'h000);
    add_vec(3'b100, 3'b000, 32'h0, 32'h0, BASE + 32'h2000, 3'b100, 1'b1, 11'h000);
    add_vec(3'b001, 3'b000, BASE - 32'h4, 32'h0, 32'h0, 3'b001, 1'b1, 11'h000);
    add_vec(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 11'h000);
    add_vec(3'b100, 3'b000, 32'h0, 32'h0, BASE + 32'h1FFC, 3'b100, 1'b0, 11'h7FF);
    // Back-to-back m0/m2, m1 idle.
    for (int r = 0; r < 4; r++) begin
      add_vec(3'b101, 3'b000, BASE + 32'h40, 32'h0, BASE + 32'h44, 3'b001, 1'b0, 11'h010);
      add_vec(3'b101, 3'b000, BASE + 32'h40, 32'h0, BASE + 32'h44, 3'b100, 1'b0, 11'h011);
    end

    // Reset held with all masters requesting.
    rst = 1'b1;
    bus.m_req = 3'b111;
    bus.m_wen = 3'b000;
    bus.m_add[0] = BASE + 32'h100;
    bus.m_add[1] = BASE + 32'h204;
    bus.m_add[2] = BASE + 32'h1FFC;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 32'(bus.m_gnt), 32'd0);
      chk("rst_cen", 32'(rom_cen), 32'd1);
    end

    // Release, grant m0, then reset lands before the response is delivered.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(bus.m_gnt), 32'd1);
    chk("pre_rst_cen", 32'(rom_cen), 32'd0);
    e.due = cyc + LAT; e.m = 0; e.rdata = rom_word(11'h040); e.opc = 1'b0;
    exp_q.push_back(e);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(bus.m_gnt), 32'd0);
    chk("mid_rst_cen", 32'(rom_cen), 32'd1);
    @(posedge clk); #1 rst = 1'b0; bus.m_req = 3'b000;
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.m_gnt), 32'd0);
    chk("post_rst_cen", 32'(rom_cen), 32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1 drive(tbl[k]);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", k), 32'(bus.m_gnt), 32'(tbl[k].gnt));
      chk($sformatf("v%0d_cen", k), 32'(rom_cen), 32'(tbl[k].cen));
      if (!tbl[k].cen) chk($sformatf("v%0d_rom_addr", k), 32'(rom_addr), 32'(tbl[k].raddr));
      if (tbl[k].gnt != 3'b000) begin
        m = 0;
        for (int i = 0; i < 3; i++) if (tbl[k].gnt[i]) m = i;
        e.due   = cyc + LAT;
        e.m     = m;
        e.rdata = tbl[k].cen ? ERR : rom_word(tbl[k].raddr);
        e.opc   = tbl[k].cen;
        exp_q.push_back(e);
      end
    end

    @(posedge clk); #1 bus.m_req = 3'b000;
    repeat (LAT + 3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
